// File: rtl/replacement_controller_pkg.sv
// Shared constants and helpers for the cache way-replacement selector.
package replacement_controller_pkg;

  localparam logic POLICY_LRU    = 1'b0;
  localparam logic POLICY_RANDOM = 1'b1;

  localparam int LFSR_WIDTH = 16;
  typedef logic [LFSR_WIDTH-1:0] lfsr_t;

  // Feedback mask for taps 16,14,13,11 (bit positions 15,13,12,10)
  localparam lfsr_t LFSR_TAPS = 16'hB400;
  localparam lfsr_t LFSR_SEED = 16'h0001;

  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  function automatic lfsr_t lfsr_step(input lfsr_t state);
    return {state[LFSR_WIDTH-2:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/replacement_controller_lru_age_update.sv
// Next-age computation for one set on an access, plus decode of its LRU way.
module lru_age_update #(
  parameter int NUMBER_OF_WAYS = 4,
  parameter int WAY_BITS       = 2
) (
  input  logic [NUMBER_OF_WAYS*WAY_BITS-1:0] ages_i,
  input  logic [WAY_BITS-1:0]                access_way_i,
  output logic [NUMBER_OF_WAYS*WAY_BITS-1:0] ages_o,
  output logic [NUMBER_OF_WAYS-1:0]          lru_onehot_o
);

  logic [WAY_BITS-1:0] accessed_age_s;
  logic [WAY_BITS-1:0] age_s;

  // Promote the accessed way to MRU and age every younger way by one
  always_comb begin
    ages_o         = '0;
    lru_onehot_o   = '0;
    age_s          = '0;
    accessed_age_s = ages_i[access_way_i*WAY_BITS +: WAY_BITS];
    for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
      age_s = ages_i[w*WAY_BITS +: WAY_BITS];
      lru_onehot_o[w] = (age_s == WAY_BITS'(NUMBER_OF_WAYS - 1));
      if (WAY_BITS'(w) == access_way_i) begin
        ages_o[w*WAY_BITS +: WAY_BITS] = '0;
      end else if (age_s < accessed_age_s) begin
        ages_o[w*WAY_BITS +: WAY_BITS] = age_s + WAY_BITS'(1);
      end else begin
        ages_o[w*WAY_BITS +: WAY_BITS] = age_s;
      end
    end
  end

endmodule

// File: rtl/replacement_controller.sv
// Per-set victim-way selector: first free way, else LRU or LFSR-random way.
module replacement_controller
  import replacement_controller_pkg::*;
#(
  parameter int NUMBER_OF_WAYS = 4,
  parameter int INDEX_BITS     = 8,
  localparam int WAY_BITS      = log2(NUMBER_OF_WAYS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUMBER_OF_WAYS-1:0] ways_in_use,
  input  logic [INDEX_BITS-1:0]     current_index,
  input  logic                      replacement_policy_select,
  input  logic [WAY_BITS-1:0]       current_access,
  input  logic                      access_valid,
  input  logic                      report,
  output logic [NUMBER_OF_WAYS-1:0] selected_way
);

  localparam int NUM_SETS     = 1 << INDEX_BITS;
  localparam int AGE_VEC_BITS = NUMBER_OF_WAYS * WAY_BITS;

  function automatic logic [AGE_VEC_BITS-1:0] reset_ages();
    logic [AGE_VEC_BITS-1:0] v;
    v = '0;
    for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
      v[w*WAY_BITS +: WAY_BITS] = WAY_BITS'(NUMBER_OF_WAYS - 1 - w);
    end
    return v;
  endfunction

  localparam logic [AGE_VEC_BITS-1:0] RESET_AGES = reset_ages();

  logic [AGE_VEC_BITS-1:0]   ages_q [NUM_SETS];
  logic [AGE_VEC_BITS-1:0]   ages_cur_s;
  logic [AGE_VEC_BITS-1:0]   ages_d;
  logic [NUMBER_OF_WAYS-1:0] lru_onehot_s;
  logic [NUMBER_OF_WAYS-1:0] first_free_s;
  logic [NUMBER_OF_WAYS-1:0] random_onehot_s;
  logic                      found_free_s;
  lfsr_t                     lfsr_q;
  lfsr_t                     lfsr_d;

  assign ages_cur_s = ages_q[current_index];
  assign lfsr_d     = lfsr_step(lfsr_q);

  lru_age_update #(
    .NUMBER_OF_WAYS (NUMBER_OF_WAYS),
    .WAY_BITS       (WAY_BITS)
  ) u_lru_age_update (
    .ages_i       (ages_cur_s),
    .access_way_i (current_access),
    .ages_o       (ages_d),
    .lru_onehot_o (lru_onehot_s)
  );

  // Age state for every set; reset restores the descending-age ordering
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        ages_q[s] <= RESET_AGES;
      end
    end else if (access_valid) begin
      ages_q[current_index] <= ages_d;
    end else begin
      ages_q[current_index] <= ages_q[current_index];
    end
  end

  // Free-running LFSR for the pseudo-random policy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Victim selection: lowest unused way takes priority over either policy
  always_comb begin
    first_free_s    = '0;
    found_free_s    = 1'b0;
    random_onehot_s = '0;
    for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
      first_free_s[w] = !ways_in_use[w] && !found_free_s;
      found_free_s    = found_free_s || !ways_in_use[w];
    end
    random_onehot_s[lfsr_q[WAY_BITS-1:0]] = 1'b1;
    if (found_free_s) begin
      selected_way = first_free_s;
    end else if (replacement_policy_select == POLICY_LRU) begin
      selected_way = lru_onehot_s;
    end else begin
      selected_way = random_onehot_s;
    end
  end

`ifndef SYNTHESIS
  // Debug trace of each recorded access
  always_ff @(posedge clock) begin
    if (!reset && access_valid && report) begin
      $display("replacement_controller: index %0d way %0d new ages %h",
               current_index, current_access, ages_d);
    end else begin
    end
  end
`endif

endmodule

// File: tb/tb_replacement_controller.sv
// Directed vector bench for replacement_controller (4 ways, 8 index bits).
module tb_replacement_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] ways_in_use;
  logic [7:0] current_index;
  logic       replacement_policy_select;
  logic [1:0] current_access;
  logic       access_valid;
  logic       report;
  logic [3:0] selected_way;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] index;
    logic [3:0] ways;
    logic       policy;
    logic       valid;
    logic [1:0] way;
    logic [3:0] expected;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] lfsr_m;
  logic [3:0]  exp_rand;

  replacement_controller #(
    .NUMBER_OF_WAYS (4),
    .INDEX_BITS     (8)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .ways_in_use               (ways_in_use),
    .current_index             (current_index),
    .replacement_policy_select (replacement_policy_select),
    .current_access            (current_access),
    .access_valid              (access_valid),
    .report                    (report),
    .selected_way              (selected_way)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; ways_in_use = 4'b0000; current_index = 8'd1;
    replacement_policy_select = 1'b0; current_access = 2'd0;
    access_valid = 1'b0; report = 1'b0;

    // Index 1 under LRU unless noted; ages start (w0..w3) = 3,2,1,0
    vecs.push_back('{8'd1, 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0010});
    vecs.push_back('{8'd1, 4'b0011, 1'b0, 1'b1, 2'd1, 4'b0100});
    vecs.push_back('{8'd1, 4'b0111, 1'b0, 1'b1, 2'd2, 4'b1000});
    vecs.push_back('{8'd1, 4'b0111, 1'b0, 1'b1, 2'd3, 4'b1000});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0010});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b1, 2'd1, 4'b0100});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b1, 2'd2, 4'b1000});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b1, 2'd3, 4'b0001});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b1, 2'd2, 4'b0001});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b1, 2'd1, 4'b0001});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b1, 2'd3, 4'b0001});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0100});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b1, 2'd2, 4'b0010});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b1, 2'd2, 4'b0010});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0010});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0010});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b0, 2'd1, 4'b0010});
    vecs.push_back('{8'd1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0001});
    vecs.push_back('{8'd2, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0001});
    vecs.push_back('{8'd1, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b0100});
    vecs.push_back('{8'd1, 4'b0110, 1'b1, 1'b0, 2'd0, 4'b0001});
    vecs.push_back('{8'd1, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0010});

    #1 check("reset_during", selected_way, 4'b0001);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1 check("reset_after", selected_way, 4'b0001);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      current_index             = vecs[i].index;
      ways_in_use               = vecs[i].ways;
      replacement_policy_select = vecs[i].policy;
      access_valid              = vecs[i].valid;
      current_access            = vecs[i].way;
      @(posedge clock);
      #1 check($sformatf("vec%0d", i), selected_way, vecs[i].expected);
    end

    // Reset restores ages and seed, and dominates a simultaneous access
    @(negedge clock);
    reset = 1'b1; access_valid = 1'b0; current_index = 8'd1;
    ways_in_use = 4'b1111; replacement_policy_select = 1'b1;
    #1 check("rst_seed", selected_way, 4'b0010);
    replacement_policy_select = 1'b0;
    #1 check("rst_ages", selected_way, 4'b0001);
    access_valid = 1'b1; current_access = 2'd0;
    @(posedge clock);
    #1 check("rst_dominates", selected_way, 4'b0001);

    // First edge after reset release records the access
    @(negedge clock);
    reset = 1'b0;
    lfsr_m = 16'h0001;
    @(posedge clock);
    lfsr_m = lfsr_adv(lfsr_m);
    #1 check("first_edge", selected_way, 4'b0010);

    @(negedge clock);
    access_valid = 1'b0; replacement_policy_select = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      lfsr_m = lfsr_adv(lfsr_m);
      exp_rand = 4'b0000;
      exp_rand[lfsr_m[1:0]] = 1'b1;
      #1 check($sformatf("rand%0d", c), selected_way, exp_rand);
    end

    // Mid-stream reset returns to the seed and the reset ages
    @(negedge clock);
    reset = 1'b1;
    #1 check("rst_mid_seed", selected_way, 4'b0010);
    replacement_policy_select = 1'b0;
    #1 check("rst_mid_ages", selected_way, 4'b0001);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/replacement_controller.md
# replacement_controller

Per-set way-replacement selector for the set-associative cache. It tracks access recency for every set, indexed by `current_index`. It produces a one-hot victim way: the lowest-numbered unused way if one exists, otherwise the way chosen by the active policy (LRU or pseudo-random). It sits beside the tag/valid arrays in the cache controller, which supplies the valid mask and reports each hit or fill.

## Interface
- `NUMBER_OF_WAYS`, 4, associativity; power of two, ≥2.
- `INDEX_BITS`, 8, set-index width; 2^INDEX_BITS sets.
- Derived `WAY_BITS` = log2(NUMBER_OF_WAYS).

Ports, in instantiation order:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ways_in_use`  in  NUMBER_OF_WAYS  valid bit per way of the indexed set (bit i = way i).
- `current_index`  in  INDEX_BITS  set being accessed or replaced.
- `replacement_policy_select`  in  1  0 = LRU, 1 = pseudo-random.
- `current_access`  in  WAY_BITS  binary way number accessed this cycle.
- `access_valid`  in  1  qualifies `current_access`.
- `report`  in  1  simulation-only debug enable; no effect on hardware behaviour.
- `selected_way`  out  NUMBER_OF_WAYS  one-hot victim way for `current_index`.

## Operation
**State per set**
- One WAY_BITS-bit age per way.
- Age 0 = MRU; age NUMBER_OF_WAYS-1 = LRU.
- Ages within a set are always a permutation of 0..N-1.

**Update**
- Trigger: rising edge with `reset`=0 and `access_valid`=1.
- Let a = `current_access` and A = the old age of way a in set `current_index`.
- Every way in that set with age < A increments by 1.
- Way a becomes 0.
- All other ways and all other sets are unchanged.
- Re-accessing the MRU way changes nothing.
- Ages update in both policy modes.

**Selection (combinational)**
- Input to selection is `ways_in_use`, the registered state of set `current_index`, and the LFSR.
- If `ways_in_use` is not all ones, `selected_way` is the one-hot of the lowest-indexed 0 bit, regardless of policy.
- Otherwise, with policy 0: one-hot of the way whose age is N-1.
- Otherwise, with policy 1: one-hot of LFSR[WAY_BITS-1:0].
- `selected_way` is always exactly one-hot.

**LFSR**
- 16-bit Fibonacci LFSR, taps 16,14,13,11.
- Seed 16'h0001 on reset.
- Advances every clock while not in reset.

**Reset**
- Every set's age[w] = N-1-w, so way 0 is LRU.
- LFSR is seeded.
- During and after reset, `selected_way` follows the selection rules from the reset state. With `ways_in_use`=0 the output is 4'b0001.

**Report**
- When `report`=1 at an update edge, `$display` the index, accessed way, and new ages.
- Guarded so it is excluded from synthesis.

## Timing
- Selection has zero latency: `selected_way` responds combinationally to `ways_in_use`, `current_index` and the policy input within the same cycle.
- An access recorded at edge k is reflected in `selected_way` immediately after edge k.
- Reset dominates any simultaneous access.
- The first edge with `reset` low records a valid access.
- Asserting reset mid-operation immediately restores every set to the reset ages.
- `current_access` out of range cannot occur, because N is a power of two.
- `access_valid`=0 is a full hold; the LFSR still advances.

## Structure
- Shared package holds:
  - the `log2` function;
  - policy encoding constants `POLICY_LRU`=0 and `POLICY_RANDOM`=1;
  - LFSR width, taps and seed.
- State is an array of 2^INDEX_BITS × (N·WAY_BITS) bits with asynchronous read and asynchronous reset.
- One natural sub-module, `lru_age_update`: a pure combinational next-age vector from (old ages, accessed way) plus LRU-way decode.
- First-free priority encoder and LFSR stay inline.

## Test plan
1. Reset, then `current_index`=1, `ways_in_use`=0000 → `selected_way`=0001.
2. Fill sequence:
   - record access 0, set ways 0001 → 0010;
   - access 1, ways 0011 → 0100;
   - access 2 then 3, ways 0111 → 1000.
3. All ways in use (1111) after accesses 0,1,2,3 under LRU → 0001.
4. Then accesses 2,1,3,0 on consecutive edges → 0100. One further access 2 → 0010.
5. Next, hold with `access_valid`=0 for several cycles → 0010 unchanged. Then `ways_in_use`=0000 → 0001.
6. Isolation and random mode:
   - accesses to index 1 leave index 2 at reset ages (LRU = way 0);
   - policy 1 with all ways valid gives one-hot LFSR[1:0] every cycle, and an assert of reset mid-stream restores seed and ages.
